// File: rtl/alu_sync_controller.sv
// Request/response sequencer between a CPU pipeline and an ALU with combinational and iterative paths.
// Optional watchdog on the iterative wait: define ALU_SYNC_CTRL_TIMEOUT_EN.
module alu_sync_controller #(
  parameter  int unsigned TIMEOUT_CYCLES = 40,
  localparam int unsigned OP_W           = 5,
  localparam int unsigned DATA_W         = 32,
  localparam int unsigned TAG_W          = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [DATA_W-1:0] req_in1,
  input  logic [DATA_W-1:0] req_in2,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic [TAG_W-1:0]  resp_tag,
  output logic              resp_error,
  output logic [OP_W-1:0]   alu_operation,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic              alu_trigger_sync,
  input  logic [DATA_W-1:0] alu_out_async,
  input  logic [DATA_W-1:0] alu_out_sync,
  input  logic              alu_result_ready,
  input  logic              alu_busy
);

  typedef enum logic [2:0] {IDLE, EVAL, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] in1;
    logic [DATA_W-1:0] in2;
    logic [TAG_W-1:0]  tag;
  } req_t;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t            state_q, state_d;
  req_t              req_q, req_d;
  logic              trig_q, trig_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              accept_c;
  logic              sync_op_c;

`ifdef ALU_SYNC_CTRL_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  assign resp_error = err_q;
`else
  assign resp_error = 1'b0;
`endif

  // Gated by reset_n so nothing is accepted while reset is held.
  assign req_ready = reset_n && (state_q == IDLE) && !alu_busy;
  assign accept_c  = req_valid && req_ready;
  assign sync_op_c = (req_op >= OP_W'(7)) && (req_op <= OP_W'(14));

  assign alu_operation    = req_q.op;
  assign alu_in1          = req_q.in1;
  assign alu_in2          = req_q.in2;
  assign resp_tag         = req_q.tag;
  assign alu_trigger_sync = trig_q;
  assign resp_valid       = valid_q;
  assign resp_data        = data_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    trig_d  = 1'b0;
    valid_d = valid_q;
    data_d  = data_q;
`ifdef ALU_SYNC_CTRL_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          req_d = '{op: req_op, in1: req_in1, in2: req_in2, tag: req_tag};
          if (sync_op_c) begin
            state_d = ISSUE;
            trig_d  = 1'b1;
          end else begin
            state_d = EVAL;
          end
        end
      end
      EVAL: begin
        data_d  = alu_out_async;
        valid_d = 1'b1;
        state_d = RESP;
`ifdef ALU_SYNC_CTRL_TIMEOUT_EN
        err_d   = 1'b0;
`endif
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef ALU_SYNC_CTRL_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      // result_ready is only trusted here, after our own trigger cleared it
      WAIT: begin
        if (alu_result_ready && !alu_busy) begin
          data_d  = alu_out_sync;
          valid_d = 1'b1;
          state_d = RESP;
`ifdef ALU_SYNC_CTRL_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
`ifdef ALU_SYNC_CTRL_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          data_d  = '0;
          err_d   = 1'b1;
          valid_d = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      RESP: begin
        if (resp_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_q   <= '0;
      trig_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      req_q   <= req_d;
      trig_q  <= trig_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

`ifdef ALU_SYNC_CTRL_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_alu_sync_controller.sv
// Bench for alu_sync_controller: directed vector table, reset/timeout sequences, random traffic
// against a small ALU model with programmable iteration count.
module tb_alu_sync_controller;

  localparam int unsigned TO = 40;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_op = '0;
  logic [31:0] req_in1 = '0;
  logic [31:0] req_in2 = '0;
  logic [4:0]  req_tag = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic [4:0]  resp_tag;
  logic        resp_error;
  logic [4:0]  alu_operation;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic        alu_trigger_sync;
  logic [31:0] alu_out_async;
  logic [31:0] alu_out_sync;
  logic        alu_result_ready;
  logic        alu_busy;

  int n_vec = 0;
  int n_bad = 0;

  alu_sync_controller #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_in1(req_in1), .req_in2(req_in2), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_tag(resp_tag), .resp_error(resp_error),
    .alu_operation(alu_operation), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_trigger_sync(alu_trigger_sync), .alu_out_async(alu_out_async),
    .alu_out_sync(alu_out_sync), .alu_result_ready(alu_result_ready), .alu_busy(alu_busy)
  );

  always #5 clock = ~clock;

  function automatic logic is_sync(input logic [4:0] op);
    return (op >= 5'd7) && (op <= 5'd14);
  endfunction

  // Behavioural ALU: result the controller must pass through untouched
  function automatic logic [31:0] alu_ref(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic        ovf;
    p   = 64'(a) * 64'(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      5'd0:  return a & b;
      5'd1:  return a | b;
      5'd2:  return a + b;
      5'd3:  return a - b;
      5'd4:  return a ^ b;
      5'd5:  return a << b[4:0];
      5'd6:  return a >> b[4:0];
      5'd7:  return p[31:0];
      5'd8, 5'd9, 5'd10: return p[63:32];
      5'd11: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      5'd12: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd13: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      5'd14: return (b == 0) ? a : a % b;
      5'd15: return 32'($signed(a) < $signed(b));
      5'd16: return 32'(a < b);
      5'd17: return 32'($signed(a) >>> b[4:0]);
      default: return ~(a ^ b);
    endcase
  endfunction

  // ALU environment: async path is combinational, sync path iterates alu_iters cycles
  int          alu_iters = 0;
  bit          stuck = 1'b0;
  bit          busy_force = 1'b0;
  logic        busy_q = 1'b0;
  logic        rdy_q = 1'b0;
  logic [31:0] out_sync_q = '0;
  logic [31:0] pend_q = '0;
  int          iter_q = 0;
  int          trig_cnt = 0;

  assign alu_out_async    = is_sync(alu_operation) ? (32'hDEAD_BEEF ^ alu_in1)
                                                   : alu_ref(alu_operation, alu_in1, alu_in2);
  assign alu_out_sync     = out_sync_q;
  assign alu_result_ready = rdy_q;
  assign alu_busy         = busy_q | busy_force;

  always @(posedge clock) begin
    if (alu_trigger_sync) begin
      trig_cnt <= trig_cnt + 1;
      pend_q   <= alu_ref(alu_operation, alu_in1, alu_in2);
      if (stuck) begin
        rdy_q  <= 1'b0;
        busy_q <= 1'b0;
      end else if (alu_iters == 0) begin
        out_sync_q <= alu_ref(alu_operation, alu_in1, alu_in2);
        rdy_q      <= 1'b1;
        busy_q     <= 1'b0;
      end else begin
        rdy_q  <= 1'b0;
        busy_q <= 1'b1;
        iter_q <= alu_iters;
      end
    end else if (busy_q) begin
      if (iter_q == 1) begin
        busy_q     <= 1'b0;
        rdy_q      <= 1'b1;
        out_sync_q <= pend_q;
      end
      iter_q <= iter_q - 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One request through to its response; latency counted in negedge samples after acceptance
  task automatic run_txn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input int iters, input int stall, input bit early,
                         input logic [31:0] exp_data, input logic exp_err, input int exp_lat);
    int w;
    int lat;
    int trig0;
    @(negedge clock);
    alu_iters  = iters;
    req_op     = op;
    req_in1    = a;
    req_in2    = b;
    req_tag    = tag;
    req_valid  = 1'b1;
    resp_ready = early;
    w = 0;
    while (!req_ready && w < 200) begin
      @(negedge clock);
      w++;
    end
    check("accept", 32'(req_ready), 32'd1);
    trig0 = trig_cnt;
    @(posedge clock);
    lat = 0;
    do begin
      @(negedge clock);
      if (lat == 0) req_valid = 1'b0;
      lat++;
    end while (!resp_valid && lat < 300);
    check("latency", 32'(lat), 32'(exp_lat));
    check("data", resp_data, exp_data);
    check("tag", 32'(resp_tag), 32'(tag));
    check("error", 32'(resp_error), 32'(exp_err));
    if (!early) begin
      for (int s = 0; s < stall; s++) begin
        @(negedge clock);
        check("stall_valid", 32'(resp_valid), 32'd1);
        check("stall_data", resp_data, exp_data);
        check("stall_ready", 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
    end
    @(negedge clock);
    resp_ready = 1'b0;
    check("valid_drop", 32'(resp_valid), 32'd0);
    check("idle_ready", 32'(req_ready), 32'd1);
    check("trig_pulses", 32'(trig_cnt - trig0), 32'(is_sync(op)));
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    int          iters;
    int          stall;
    bit          early;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int w;
    logic [4:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    int          r_it;

    vecs[0] = '{5'd7,  32'd7,          32'd6,          5'd3,  0, 0, 1'b0, 32'd42,          3};
    vecs[1] = '{5'd2,  32'd5,          32'd3,          5'd9,  0, 0, 1'b0, 32'd8,           2};
    vecs[2] = '{5'd12, 32'd100,        32'd0,          5'd17, 0, 0, 1'b0, 32'hFFFF_FFFF,   3};
    vecs[3] = '{5'd11, 32'hFFFF_FF9C,  32'd7,          5'd30, 4, 3, 1'b0, 32'hFFFF_FFF2,   7};
    vecs[4] = '{5'd3,  32'd3,          32'd10,         5'd1,  0, 1, 1'b0, 32'hFFFF_FFF9,   2};
    vecs[5] = '{5'd14, 32'd17,         32'd5,          5'd31, 2, 0, 1'b1, 32'd2,           5};
    vecs[6] = '{5'd16, 32'd5,          32'd6,          5'd0,  0, 0, 1'b1, 32'd1,           2};
    vecs[7] = '{5'd10, 32'hFFFF_FFFF,  32'd2,          5'd12, 1, 0, 1'b0, 32'd1,           4};
    vecs[8] = '{5'd15, 32'hFFFF_FFFF,  32'd1,          5'd5,  0, 0, 1'b0, 32'd1,           2};
    vecs[9] = '{5'd6,  32'h8000_0000,  32'd31,         5'd22, 0, 2, 1'b0, 32'd1,           2};

    // Reset state while reset is held
    repeat (2) @(negedge clock);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_trigger", 32'(alu_trigger_sync), 32'd0);
    check("rst_alu_op", 32'(alu_operation), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    check("post_rst_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 10; i++)
      run_txn(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].iters, vecs[i].stall,
              vecs[i].early, vecs[i].exp_data, 1'b0, vecs[i].exp_lat);

    // Reset during WAIT of a long DIVU while the ALU stays busy
    @(negedge clock);
    alu_iters = 20;
    req_op = 5'd12; req_in1 = 32'd1000; req_in2 = 32'd3; req_tag = 5'd21;
    req_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    repeat (3) @(negedge clock);
    busy_force = 1'b1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_req_ready", 32'(req_ready), 32'd0);
    check("mid_rst_valid", 32'(resp_valid), 32'd0);
    check("mid_rst_data", resp_data, 32'd0);
    check("mid_rst_tag", 32'(resp_tag), 32'd0);
    check("mid_rst_error", 32'(resp_error), 32'd0);
    check("mid_rst_trigger", 32'(alu_trigger_sync), 32'd0);
    check("mid_rst_op", 32'(alu_operation), 32'd0);
    check("mid_rst_in1", alu_in1, 32'd0);
    check("mid_rst_in2", alu_in2, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("busy_hold_ready", 32'(req_ready), 32'd0);
      check("busy_hold_valid", 32'(resp_valid), 32'd0);
    end
    busy_force = 1'b0;
    w = 0;
    while (!req_ready && w < 60) begin
      @(negedge clock);
      w++;
    end
    check("busy_release_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("no_stale_resp", 32'(resp_valid), 32'd0);
    end
    run_txn(5'd12, 32'd1000, 32'd3, 5'd21, 2, 0, 1'b0, 32'd333, 1'b0, 5);

`ifdef ALU_SYNC_CTRL_TIMEOUT_EN
    stuck = 1'b1;
    run_txn(5'd7, 32'd7, 32'd6, 5'd4, 0, 2, 1'b0, 32'd0, 1'b1, 2 + int'(TO));
    stuck = 1'b0;
`endif

    // Random traffic against the reference ALU and the latency rule
    for (int i = 0; i < 40; i++) begin
      r_op = 5'($urandom_range(0, 17));
      r_a  = $urandom;
      r_b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      r_it = $urandom_range(0, 6);
      run_txn(r_op, r_a, r_b, 5'($urandom_range(0, 31)), r_it, $urandom_range(0, 3),
              ($urandom_range(0, 3) == 0), alu_ref(r_op, r_a, r_b), 1'b0,
              is_sync(r_op) ? 3 + r_it : 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
